alu_issue: RTL and testbench

- Producer side of the ALU operation interface.
- Decodes a MIPS instruction's opcode/funct, selects and extends the two operands, and drives the 4-bit ALU command.
- Holds all three in a registered ID/EX issue stage with a valid/ready handshake, stall hold and flush.
- Sits between the decode stage and the ALU in the execute stage.

---
 rtl/alu_issue_if.sv | 20 ++
 rtl/alu_issue.sv | 132 +++++++++++++
 tb/tb_alu_issue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: issue-stage -> ALU operation bus.
//   out_valid/out_ready : payload handshake (producer drives valid, ALU drives ready)
//   alucontrol          : 4-bit ALU command
//   op_a/op_b           : ALU operands
//   illegal             : registered instruction could not be decoded
// master = issue stage (producer), slave = ALU (consumer).
interface alu_issue_if #(
  parameter int WORD_LEN    = 32,
  parameter int EXE_CMD_LEN = 3
);
  logic                 out_valid;
  logic                 out_ready;
  logic [EXE_CMD_LEN:0] alucontrol;
  logic [WORD_LEN-1:0]  op_a;
  logic [WORD_LEN-1:0]  op_b;
  logic                 illegal;

  modport master (output out_valid, alucontrol, op_a, op_b, illegal, input out_ready);
  modport slave  (input out_valid, alucontrol, op_a, op_b, illegal, output out_ready);
endinterface

// File: rtl/alu_issue.sv
// alu_issue: ID/EX issue register for the ALU.
// Decodes opcode/funct, selects/extends operands, registers {cmd, a, b, illegal}
// behind a valid/ready handshake with stall hold and flush.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : decode-side handshake (in_ready = !out_valid || out_ready)
//   opcode,funct,shamt,imm16 : instruction fields
//   rs_val, rt_val      : forwarded register values
//   flush               : squash the issue register next cycle
//   alu                 : ALU operation bus (master side)
//   issue_count         : wrapping count of handoffs to EX
module alu_issue #(
  parameter int WORD_LEN    = 32,
  parameter int EXE_CMD_LEN = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic [4:0]          shamt,
  input  logic [15:0]         imm16,
  input  logic [WORD_LEN-1:0] rs_val,
  input  logic [WORD_LEN-1:0] rt_val,
  input  logic                flush,
  alu_issue_if.master         alu,
  output logic [15:0]         issue_count
);

  localparam int CW = EXE_CMD_LEN + 1;
  localparam logic [CW-1:0] CMD_ADD = CW'(4'b0010);
  localparam logic [CW-1:0] CMD_SUB = CW'(4'b0110);
  localparam logic [CW-1:0] CMD_AND = CW'(4'b0000);
  localparam logic [CW-1:0] CMD_OR  = CW'(4'b0001);
  localparam logic [CW-1:0] CMD_SLT = CW'(4'b0111);
  localparam logic [CW-1:0] CMD_XOR = CW'(4'b1100);
  localparam logic [CW-1:0] CMD_NOR = CW'(4'b1101);
  localparam logic [CW-1:0] CMD_SLL = CW'(4'b1000);
  localparam logic [CW-1:0] CMD_SRL = CW'(4'b1010);
  localparam logic [CW-1:0] CMD_SRA = CW'(4'b1011);

  typedef struct packed {
    logic [CW-1:0]       cmd;
    logic [WORD_LEN-1:0] a;
    logic [WORD_LEN-1:0] b;
    logic                ill;
  } payload_t;

  payload_t            dec;
  payload_t            pay_d, pay_q;
  logic                vld_d, vld_q;
  logic [15:0]         cnt_d, cnt_q;
  logic [WORD_LEN-1:0] se, ze, sh_imm, sh_reg;
  logic                load, handoff;

  assign se     = {{(WORD_LEN-16){imm16[15]}}, imm16};
  assign ze     = {{(WORD_LEN-16){1'b0}}, imm16};
  assign sh_imm = {{(WORD_LEN-5){1'b0}}, shamt};
  assign sh_reg = {{(WORD_LEN-5){1'b0}}, rs_val[4:0]};

  // Undecodable encodings leave cmd/a/b at zero and raise ill; they still
  // issue so EX can take the exception in order.
  always_comb begin
    dec = '0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: begin dec.cmd = CMD_ADD; dec.a = rs_val; dec.b = rt_val; end
          6'h22, 6'h23: begin dec.cmd = CMD_SUB; dec.a = rs_val; dec.b = rt_val; end
          6'h24:        begin dec.cmd = CMD_AND; dec.a = rs_val; dec.b = rt_val; end
          6'h25:        begin dec.cmd = CMD_OR;  dec.a = rs_val; dec.b = rt_val; end
          6'h26:        begin dec.cmd = CMD_XOR; dec.a = rs_val; dec.b = rt_val; end
          6'h27:        begin dec.cmd = CMD_NOR; dec.a = rs_val; dec.b = rt_val; end
          6'h2A, 6'h2B: begin dec.cmd = CMD_SLT; dec.a = rs_val; dec.b = rt_val; end
          6'h00:        begin dec.cmd = CMD_SLL; dec.a = rt_val; dec.b = sh_imm; end
          6'h02:        begin dec.cmd = CMD_SRL; dec.a = rt_val; dec.b = sh_imm; end
          6'h03:        begin dec.cmd = CMD_SRA; dec.a = rt_val; dec.b = sh_imm; end
          6'h04:        begin dec.cmd = CMD_SLL; dec.a = rt_val; dec.b = sh_reg; end
          6'h06:        begin dec.cmd = CMD_SRL; dec.a = rt_val; dec.b = sh_reg; end
          6'h07:        begin dec.cmd = CMD_SRA; dec.a = rt_val; dec.b = sh_reg; end
          default:      dec.ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin dec.cmd = CMD_ADD; dec.a = rs_val; dec.b = se; end
      6'h0A, 6'h0B: begin dec.cmd = CMD_SLT; dec.a = rs_val; dec.b = se; end
      6'h0C:        begin dec.cmd = CMD_AND; dec.a = rs_val; dec.b = ze; end
      6'h0D:        begin dec.cmd = CMD_OR;  dec.a = rs_val; dec.b = ze; end
      6'h0E:        begin dec.cmd = CMD_XOR; dec.a = rs_val; dec.b = ze; end
      // LUI realised as imm << 16 on the ALU shifter
      6'h0F:        begin dec.cmd = CMD_SLL; dec.a = ze; dec.b = WORD_LEN'(16); end
      6'h23, 6'h2B: begin dec.cmd = CMD_ADD; dec.a = rs_val; dec.b = se; end
      6'h04, 6'h05: begin dec.cmd = CMD_SUB; dec.a = rs_val; dec.b = rt_val; end
      default:      dec.ill = 1'b1;
    endcase
  end

  assign in_ready = !vld_q || alu.out_ready;
  assign handoff  = vld_q && alu.out_ready;
  // An instruction offered during flush is dropped, not loaded.
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    vld_d = vld_q;
    pay_d = pay_q;
    cnt_d = cnt_q;
    if (handoff) cnt_d = cnt_q + 16'd1;
    if (flush)        vld_d = 1'b0;
    else if (load)    begin vld_d = 1'b1; pay_d = dec; end
    else if (handoff) vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      pay_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      pay_q <= pay_d;
      cnt_q <= cnt_d;
    end
  end

  assign alu.out_valid  = vld_q;
  assign alu.alucontrol = pay_q.cmd;
  assign alu.op_a       = pay_q.a;
  assign alu.op_b       = pay_q.b;
  assign alu.illegal    = pay_q.ill;
  assign issue_count    = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic        in_ready;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [31:0] rs_val, rt_val;
  logic [15:0] issue_count;

  alu_issue_if #(.WORD_LEN(32), .EXE_CMD_LEN(3)) alu();
  assign alu.out_ready = out_ready;

  alu_issue #(.WORD_LEN(32), .EXE_CMD_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .shamt(shamt), .imm16(imm16),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .alu(alu),
    .issue_count(issue_count));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [3:0] cmd; logic [31:0] a; logic [31:0] b; logic ill; } dec_t;

  function automatic dec_t ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [4:0] sh, input logic [15:0] im,
                                   input logic [31:0] rs, input logic [31:0] rt);
    dec_t r;
    logic [31:0] sx, zx;
    sx = 32'(signed'(im));
    zx = 32'(im);
    r = '{4'h0, 32'h0, 32'h0, 1'b0};
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h21})      r = '{4'b0010, rs, rt, 1'b0};
      else if (fn inside {6'h22, 6'h23}) r = '{4'b0110, rs, rt, 1'b0};
      else if (fn == 6'h24)              r = '{4'b0000, rs, rt, 1'b0};
      else if (fn == 6'h25)              r = '{4'b0001, rs, rt, 1'b0};
      else if (fn == 6'h26)              r = '{4'b1100, rs, rt, 1'b0};
      else if (fn == 6'h27)              r = '{4'b1101, rs, rt, 1'b0};
      else if (fn inside {6'h2A, 6'h2B}) r = '{4'b0111, rs, rt, 1'b0};
      else if (fn == 6'h00)              r = '{4'b1000, rt, 32'(sh), 1'b0};
      else if (fn == 6'h02)              r = '{4'b1010, rt, 32'(sh), 1'b0};
      else if (fn == 6'h03)              r = '{4'b1011, rt, 32'(sh), 1'b0};
      else if (fn == 6'h04)              r = '{4'b1000, rt, rs % 32, 1'b0};
      else if (fn == 6'h06)              r = '{4'b1010, rt, rs % 32, 1'b0};
      else if (fn == 6'h07)              r = '{4'b1011, rt, rs % 32, 1'b0};
      else                               r.ill = 1'b1;
    end
    else if (op inside {6'h08, 6'h09, 6'h23, 6'h2B}) r = '{4'b0010, rs, sx, 1'b0};
    else if (op inside {6'h0A, 6'h0B}) r = '{4'b0111, rs, sx, 1'b0};
    else if (op == 6'h0C)              r = '{4'b0000, rs, zx, 1'b0};
    else if (op == 6'h0D)              r = '{4'b0001, rs, zx, 1'b0};
    else if (op == 6'h0E)              r = '{4'b1100, rs, zx, 1'b0};
    else if (op == 6'h0F)              r = '{4'b1000, zx, 32'd16, 1'b0};
    else if (op inside {6'h04, 6'h05}) r = '{4'b0110, rs, rt, 1'b0};
    else                               r.ill = 1'b1;
    return r;
  endfunction

  bit          m_valid;
  dec_t        m_pay;
  logic [15:0] m_cnt;

  always @(posedge clk) begin
    bit hand, rdy;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_pay   = '{4'h0, 32'h0, 32'h0, 1'b0};
      m_cnt   = 16'h0;
    end else begin
      hand = m_valid && out_ready;
      rdy  = !m_valid || out_ready;
      if (hand) m_cnt = m_cnt + 16'h1;
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin
        m_valid = 1'b1;
        m_pay   = ref_dec(opcode, funct, shamt, imm16, rs_val, rt_val);
      end else if (hand) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("out_valid", 32'(alu.out_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      check("issue_count", 32'(issue_count), 32'(m_cnt));
      if (m_valid) begin
        check("alucontrol", 32'(alu.alucontrol), 32'(m_pay.cmd));
        check("op_a", alu.op_a, m_pay.a);
        check("op_b", alu.op_b, m_pay.b);
        check("illegal", 32'(alu.illegal), 32'(m_pay.ill));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
    opcode = op; funct = fn; shamt = sh; imm16 = im; rs_val = rs; rt_val = rt;
  endtask

  function automatic logic [5:0] rfun();
    case ($urandom_range(0, 17))
      0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
      4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
      8: return 6'h2A;  9: return 6'h2B; 10: return 6'h00; 11: return 6'h02;
      12: return 6'h03; 13: return 6'h04; 14: return 6'h06; 15: return 6'h07;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] iop();
    case ($urandom_range(0, 12))
      0: return 6'h08;  1: return 6'h09;  2: return 6'h0A;  3: return 6'h0B;
      4: return 6'h0C;  5: return 6'h0D;  6: return 6'h0E;  7: return 6'h0F;
      8: return 6'h23;  9: return 6'h2B; 10: return 6'h04; 11: return 6'h05;
      default: return 6'($urandom);
    endcase
  endfunction

  task automatic rand_instr();
    int k;
    k = $urandom_range(0, 9);
    set_in(6'($urandom), 6'($urandom), 5'($urandom), 16'($urandom), $urandom, $urandom);
    if (k < 4) begin opcode = 6'h00; funct = rfun(); end
    else if (k < 9) opcode = iop();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set_in(6'h00, 6'h22, 5'd0, 16'h0, 32'd10, 32'd3);
    cyc(); cyc();
    chk_on = 1'b1;
    check("rst out_valid", 32'(alu.out_valid), 32'd0);
    check("rst alucontrol", 32'(alu.alucontrol), 32'd0);
    check("rst op_a", alu.op_a, 32'd0);
    check("rst op_b", alu.op_b, 32'd0);
    check("rst illegal", 32'(alu.illegal), 32'd0);
    check("rst issue_count", 32'(issue_count), 32'd0);

    rst_n = 1'b1; cyc();
    check("sub valid", 32'(alu.out_valid), 32'd1);
    check("sub cmd", 32'(alu.alucontrol), 32'b0110);
    check("sub a", alu.op_a, 32'd10);
    check("sub b", alu.op_b, 32'd3);

    set_in(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd7); cyc();
    check("addi cmd", 32'(alu.alucontrol), 32'b0010);
    check("addi b", alu.op_b, 32'hFFFFFFFF);
    check("addi count", 32'(issue_count), 32'd1);

    set_in(6'h0D, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd7); cyc();
    check("ori cmd", 32'(alu.alucontrol), 32'b0001);
    check("ori b", alu.op_b, 32'h0000FFFF);

    set_in(6'h00, 6'h03, 5'd4, 16'h0, 32'd0, 32'h80000000); cyc();
    check("sra cmd", 32'(alu.alucontrol), 32'b1011);
    check("sra a", alu.op_a, 32'h80000000);
    check("sra b", alu.op_b, 32'd4);

    set_in(6'h00, 6'h06, 5'd0, 16'h0, 32'h25, 32'h11); cyc();
    check("srlv b", alu.op_b, 32'd5);

    set_in(6'h0F, 6'h00, 5'd0, 16'h1234, 32'd9, 32'd9); cyc();
    check("lui cmd", 32'(alu.alucontrol), 32'b1000);
    check("lui a", alu.op_a, 32'h1234);
    check("lui b", alu.op_b, 32'd16);
    check("lui count", 32'(issue_count), 32'd5);

    out_ready = 1'b0;
    set_in(6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall in_ready", 32'(in_ready), 32'd0);
      check("stall cmd", 32'(alu.alucontrol), 32'b1000);
      check("stall a", alu.op_a, 32'h1234);
      check("stall count", 32'(issue_count), 32'd5);
    end
    out_ready = 1'b1; cyc();
    check("post-stall cmd", 32'(alu.alucontrol), 32'b0010);
    check("post-stall a", alu.op_a, 32'd1);
    check("post-stall count", 32'(issue_count), 32'd6);

    out_ready = 1'b0; flush = 1'b1;
    set_in(6'h00, 6'h24, 5'd0, 16'h0, 32'hAA, 32'h55); cyc();
    check("flush valid", 32'(alu.out_valid), 32'd0);
    check("flush count", 32'(issue_count), 32'd6);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cyc();
    check("flush dropped", 32'(alu.out_valid), 32'd0);

    in_valid = 1'b1;
    set_in(6'h3F, 6'h00, 5'd0, 16'h1, 32'h1, 32'h1); cyc();
    check("ill flag", 32'(alu.illegal), 32'd1);
    check("ill valid", 32'(alu.out_valid), 32'd1);
    check("ill cmd", 32'(alu.alucontrol), 32'd0);
    check("ill a", alu.op_a, 32'd0);
    set_in(6'h00, 6'h24, 5'd0, 16'h0, 32'hF0, 32'h3C); cyc();
    check("legal after ill", 32'(alu.illegal), 32'd0);
    check("and b", alu.op_b, 32'h3C);
    check("ill count", 32'(issue_count), 32'd7);

    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      rand_instr();
      cyc();
    end

    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    n = 0;
    while (m_cnt != 16'hFFFF && n < 70000) begin
      rand_instr(); cyc(); n++;
    end
    if (n >= 70000) check("wrap reach bound", 32'(n), 32'd0);
    check("count at max", 32'(issue_count), 32'hFFFF);
    rand_instr(); cyc();
    check("count wrap", 32'(issue_count), 32'd0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
